// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared types, constants and helpers for the serializer
package serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ser_state_t;

    localparam int SER_WIDTH = 8;

    // Even parity of a word; narrower words are zero-extended by the caller,
    // which leaves the XOR reduction unchanged.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/serializer.sv
// rtl/serializer.sv - parallel-to-serial converter with per-bit ack; optional parity via SERIALIZER_PARITY_EN
module serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                          clock_10,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              data_in,
    input  logic                          write_in,
    output logic                          status_out,
    output logic                          data_out,
    output logic                          valid_out,
    input  logic                          ack_in,
    output logic                          done_out,
    output logic [$clog2(WIDTH+2)-1:0]    bit_cnt_out
);

`ifdef SERIALIZER_PARITY_EN
    localparam int TOTAL = WIDTH + 1;
`else
    localparam int TOTAL = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);

    ser_state_t        state, state_next;
    logic [TOTAL-1:0]  sreg;
    logic [TOTAL-1:0]  load_word;
    logic [CW-1:0]     cnt;
    logic              out_bit;
    logic              last_ack;

    // Word image loaded at capture; the parity bit sits at the far end from
    // the output so it leaves after all data bits.
    always_comb begin
`ifdef SERIALIZER_PARITY_EN
        logic par;
        par = even_parity(64'(data_in));
        load_word = MSB_FIRST ? {data_in, par} : {par, data_in};
`else
        load_word = data_in;
`endif
    end

    assign out_bit     = MSB_FIRST ? sreg[TOTAL-1] : sreg[0];
    assign last_ack    = ack_in && (cnt == CW'(TOTAL - 1));
    assign bit_cnt_out = cnt;

    // State register; reset drops any partial word without a done pulse.
    always_ff @(posedge clock_10 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; data_out is forced low unless a bit is valid.
    always_comb begin
        state_next = state;
        status_out = 1'b0;
        valid_out  = 1'b0;
        done_out   = 1'b0;
        case (state)
            IDLE: begin
                status_out = 1'b1;
                if (write_in) state_next = SHIFT;
            end
            SHIFT: begin
                valid_out = 1'b1;
                if (last_ack) state_next = DONE;
            end
            DONE: begin
                done_out   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        data_out = valid_out & out_bit;
    end

    // Shift register and acked-bit counter; writes outside IDLE and acks
    // outside SHIFT have no effect.
    always_ff @(posedge clock_10 or negedge reset) begin
        if (!reset) begin
            sreg <= '0;
            cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (write_in) begin
                        sreg <= load_word;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    if (ack_in) begin
                        sreg <= MSB_FIRST ? {sreg[TOTAL-2:0], 1'b0}
                                          : {1'b0, sreg[TOTAL-1:1]};
                        cnt  <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serializer.sv
// tb/tb_serializer.sv - self-checking bench for serializer (table vectors plus scoreboard)
`timescale 1us/1ns
module tb_serializer;

`ifdef SERIALIZER_PARITY_EN
    localparam int TOTAL = 9;
    localparam bit PAR   = 1'b1;
`else
    localparam int TOTAL = 8;
    localparam bit PAR   = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       write_in;
    logic       ack_in;
    logic       status, dout, valid, done;
    logic [3:0] cnt;

    logic [7:0] l_data;
    logic       l_write;
    logic       l_ack;
    logic       l_status, l_dout, l_valid, l_done;
    logic [3:0] l_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic [7:0] seq;
        logic       par;
        int         ack_mode;
        int         drop_at;
    } vec_t;

    vec_t tbl[7];

    serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clock_10   (clk),
        .reset      (rst_n),
        .data_in    (data_in),
        .write_in   (write_in),
        .status_out (status),
        .data_out   (dout),
        .valid_out  (valid),
        .ack_in     (ack_in),
        .done_out   (done),
        .bit_cnt_out(cnt)
    );

    serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clock_10   (clk),
        .reset      (rst_n),
        .data_in    (l_data),
        .write_in   (l_write),
        .status_out (l_status),
        .data_out   (l_dout),
        .valid_out  (l_valid),
        .ack_in     (l_ack),
        .done_out   (l_done),
        .bit_cnt_out(l_cnt)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    initial begin
        #(100 * 20000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_word(input vec_t v);
        int   cyc;
        int   acked;
        logic a;
        exp_q.delete();
        for (int i = 7; i >= 0; i--) exp_q.push_back(v.seq[i]);
        if (PAR) exp_q.push_back(v.par);
        chk("idle_status", status, 1);
        data_in  = v.data;
        write_in = 1'b1;
        ack_in   = 1'b0;
        @(negedge clk);
        write_in = 1'b0;
        acked = 0;
        cyc   = 1;
        while (acked < TOTAL && cyc < 200) begin
            chk("valid", valid, 1);
            if (exp_q.size() == 0) chk("queue_empty", 1, 0);
            else                   chk("bit", dout, exp_q[0]);
            chk("cnt", cnt, acked);
            chk("status_shift", status, 0);
            chk("no_early_done", done, 0);
            case (v.ack_mode)
                0:       a = 1'b1;
                1:       a = (cyc % 3 == 1);
                default: a = 1'($urandom_range(0, 1));
            endcase
            ack_in = a;
            if (cyc == v.drop_at) begin
                data_in  = 8'h22;
                write_in = 1'b1;
            end else begin
                write_in = 1'b0;
            end
            @(negedge clk);
            if (a) begin
                void'(exp_q.pop_front());
                acked++;
            end
            cyc++;
        end
        write_in = 1'b0;
        ack_in   = 1'b1;
        chk("ack_bound", acked, TOTAL);
        if (v.ack_mode == 0) chk("done_latency", cyc, TOTAL + 1);
        chk("done_pulse", done, 1);
        chk("valid_done", valid, 0);
        chk("status_done", status, 0);
        chk("cnt_done", cnt, TOTAL);
        @(negedge clk);
        chk("done_single", done, 0);
        chk("status_back", status, 1);
        chk("valid_idle", valid, 0);
        chk("cnt_idle_ack_ignored", cnt, TOTAL);
        ack_in = 1'b0;
    endtask

    initial begin
        logic lexp[$];
        rst_n    = 1'b0;
        data_in  = '0;
        write_in = 1'b0;
        ack_in   = 1'b0;
        l_data   = '0;
        l_write  = 1'b0;
        l_ack    = 1'b0;
        #20;
        chk("rst_status", status, 1);
        chk("rst_valid", valid, 0);
        chk("rst_data", dout, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        tbl[0] = '{8'hA5, 8'b10100101, 1'b0, 0, 0};
        tbl[1] = '{8'h3C, 8'b00111100, 1'b0, 1, 0};
        tbl[2] = '{8'h11, 8'b00010001, 1'b0, 0, 3};
        tbl[3] = '{8'h22, 8'b00100010, 1'b0, 0, 0};
        tbl[4] = '{8'h07, 8'b00000111, 1'b1, 0, TOTAL};
        tbl[5] = '{8'h03, 8'b00000011, 1'b0, 2, 0};
        tbl[6] = '{8'hFF, 8'b11111111, 1'b0, 1, 0};
        for (int k = 0; k < 7; k++) run_word(tbl[k]);

        // Reset mid-word after three acks.
        data_in  = 8'hFF;
        write_in = 1'b1;
        @(negedge clk);
        write_in = 1'b0;
        ack_in   = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_reset_cnt", cnt, 3);
        chk("pre_reset_valid", valid, 1);
        ack_in = 1'b0;
        #10 rst_n = 1'b0;
        #1;
        chk("async_status", status, 1);
        chk("async_valid", valid, 0);
        chk("async_data", dout, 0);
        chk("async_done", done, 0);
        chk("async_cnt", cnt, 0);
        @(negedge clk);
        chk("held_status", status, 1);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_done_after_reset", done, 0);
            chk("idle_after_reset", status, 1);
        end
        run_word('{8'h81, 8'b10000001, 1'b0, 0, 0});

        // LSB-first instance.
        lexp.delete();
        lexp.push_back(1'b1);
        for (int i = 0; i < 7; i++) lexp.push_back(1'b0);
        if (PAR) lexp.push_back(1'b1);
        l_data  = 8'h01;
        l_write = 1'b1;
        @(negedge clk);
        l_write = 1'b0;
        l_ack   = 1'b1;
        for (int i = 0; i < TOTAL; i++) begin
            chk("lsb_valid", l_valid, 1);
            chk("lsb_bit", l_dout, lexp[i]);
            @(negedge clk);
        end
        l_ack = 1'b0;
        chk("lsb_done", l_done, 1);
        @(negedge clk);
        chk("lsb_status", l_status, 1);
        chk("lsb_cnt", l_cnt, TOTAL);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Parallel-to-serial converter; the transmit-side counterpart of the deserializer datapath.
- Accepts one WIDTH-bit word through a valid/ready-style handshake.
- Shifts the word out one bit at a time to a downstream bit sink, with per-bit acknowledge (backpressure).
- Pulses done_out when the last bit has been accepted. Sits between the byte queue's output and the serial link.

Parameters:
- WIDTH, 8, word width in bits (must be ≥2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.

Ports:
- clock_10  input  1  system clock, 10 kHz; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  word to serialize.
- write_in  input  1  word-valid strobe from upstream.
- status_out  output  1  1 = ready to accept a word.
- data_out  output  1  current serial bit.
- valid_out  output  1  data_out holds a valid bit.
- ack_in  input  1  sink consumed the current bit.
- done_out  output  1  one-cycle pulse after the final bit is acked.
- bit_cnt_out  output  $clog2(WIDTH+2)  bits already acked in the current word.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - status_out=1; data_out, valid_out, done_out and bit_cnt_out = 0.
  - Shift register is cleared.
  - Reset during SHIFT discards the partial word; no done_out is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - status_out=1, valid_out=0.
  - On an edge with write_in=1: capture data_in into the shift register, clear bit_cnt_out, go to SHIFT.
- SHIFT:
  - status_out=0, valid_out=1.
  - data_out = MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0) of the shift register.
  - On an edge with ack_in=1: shift by one toward the output end and increment bit_cnt_out.
  - On the ack of the final bit (bit_cnt_out == total-1): go to DONE.
  - With ack_in=0: data_out and valid_out hold stable indefinitely.
- DONE:
  - Lasts exactly one cycle: done_out=1, valid_out=0, status_out=0.
  - Unconditionally returns to IDLE.
- Latency and throughput:
  - First bit is valid the cycle after write acceptance.
  - With ack_in held high: done_out is high in cycle total+1 after acceptance.
  - Next word can be accepted in cycle total+2.
  - Minimum word period is total+2 cycles.
- Ignored inputs:
  - write_in while status_out=0 is ignored; data is dropped and there is no side effect.
  - ack_in while valid_out=0 is ignored.
- Boundary: write_in and the final ack in the same cycle leaves the write ignored, since status_out=0 in SHIFT.
- total = WIDTH, plus 1 when parity is enabled.
- Counter width must hold WIDTH+1 without overflow.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the captured word) is appended after the data bits. total = WIDTH+1.
  - Parity is computed at capture time.
  - The parity bit follows the same ack rule as data bits.
  - done_out fires after the parity bit is acked.
- Undefined:
  - No parity logic; total = WIDTH.

Decomposition:
- Package serializer_pkg holds:
  - state enum typedef ser_state_t {IDLE, SHIFT, DONE};
  - default width constant SER_WIDTH=8;
  - function even_parity(word) for the parity feature.
- No sub-module is required; a single flat module (FSM plus shift register plus counter) is expected.

Test Plan:
- Reset, then write 0xA5 with ack_in held 1 and MSB_FIRST=1 → data_out sequence 1,0,1,0,0,1,0,1 on consecutive cycles 1–8 after acceptance; done_out=1 in cycle 9; status_out=1 in cycle 10.
- Write 0x3C, ack_in toggled 1,0,0,1,… → each bit is held while ack_in=0; bit_cnt_out advances only on acked edges; sequence 0,0,1,1,1,1,0,0; exactly one done_out pulse.
- Write 0x11, then write 0x22 during SHIFT → 0x22 is dropped; only 0x11 bits appear; after IDLE, a write of 0x22 serializes correctly.
- Write 0xFF, assert reset after the third ack → all outputs 0 and status_out=1 immediately (asynchronously); no done_out; a following write of 0x81 serializes 1,0,0,0,0,0,0,1.
- MSB_FIRST=0, write 0x01 → first bit 1, then seven 0s.
- SERIALIZER_PARITY_EN defined, write 0x07 → eight data bits followed by parity bit 1; done_out comes 10 cycles after acceptance. Write 0x03 → parity bit 0.
